spi_xfer_ctrl: RTL and testbench

Transaction sequencer for the SPI master datapath. It generates SCLK and CS_n. It also issues the enable and per-edge strobes that drive the SIPO receive register (EnSIPO, SCLKEdgeFlg) and the PISO transmit register (EnPISO, LoadPISO, shift strobe). It supports all four CPOL/CPHA modes, a programmable SCLK divider, and a Start/Busy/Done handshake to the host logic.

---
 rtl/spi_xfer_ctrl.sv | 171 +++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - SPI master transaction sequencer: SCLK/CS_n generation and SIPO/PISO strobes
module spi_xfer_ctrl #(
  parameter int WordLen = 8,
  parameter int DivW    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Start,
  input  logic [DivW-1:0] ClkDiv,
  input  logic            CPOL,
  input  logic            CPHA,
  output logic            Busy,
  output logic            Done,
  output logic            SCLK,
  output logic            CS_n,
  output logic            EnSIPO,
  output logic            SCLKEdgeFlg,
  output logic            EnPISO,
  output logic            LoadPISO,
  output logic            ShiftFlg
);

  localparam int EcW = $clog2(2 * WordLen);
  localparam logic [EcW-1:0] LastEdge = EcW'(2 * WordLen - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

  state_t          state, state_n;
  logic [DivW-1:0] hc, hc_n;
  logic [EcW-1:0]  ec, ec_n;
  logic [DivW-1:0] div_q, div_n;
  logic            cpol_q, cpol_n, cpha_q, cpha_n;
  logic            busy_n, done_n, sclk_n, csn_n, en_n, edge_n, load_n, shift_n;

  // Edge index 0 is the first (leading) edge; returns {sample, shift}.
  function automatic logic [1:0] edge_strobes(input logic [EcW-1:0] idx, input logic cpha);
    logic lead, first, last;
    lead  = ~idx[0];
    first = (idx == '0);
    last  = (idx == LastEdge);
    if (!cpha) edge_strobes = {lead, ~lead & ~last};
    else       edge_strobes = {~lead, lead & ~first};
  endfunction

  always_comb begin
    state_n = state;
    hc_n    = hc;
    ec_n    = ec;
    div_n   = div_q;
    cpol_n  = cpol_q;
    cpha_n  = cpha_q;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    sclk_n  = SCLK;
    csn_n   = 1'b1;
    en_n    = 1'b0;
    edge_n  = 1'b0;
    load_n  = 1'b0;
    shift_n = 1'b0;
    case (state)
      IDLE: begin
        sclk_n = CPOL;
        if (Start) begin
          div_n   = ClkDiv;
          cpol_n  = CPOL;
          cpha_n  = CPHA;
          hc_n    = '0;
          ec_n    = '0;
          state_n = SETUP;
          busy_n  = 1'b1;
          csn_n   = 1'b0;
          en_n    = 1'b1;
          load_n  = 1'b1;
        end
      end
      SETUP: begin
        busy_n = 1'b1;
        csn_n  = 1'b0;
        en_n   = 1'b1;
        sclk_n = cpol_q;
        if (hc == div_q) begin
          hc_n              = '0;
          ec_n              = '0;
          state_n           = XFER;
          sclk_n            = ~cpol_q;
          {edge_n, shift_n} = edge_strobes('0, cpha_q);
        end else begin
          hc_n = hc + DivW'(1);
        end
      end
      XFER: begin
        busy_n = 1'b1;
        csn_n  = 1'b0;
        en_n   = 1'b1;
        if (hc == div_q) begin
          hc_n = '0;
          // The last edge has already returned SCLK to idle; its half-period ends here.
          if (ec == LastEdge) begin
            state_n = HOLD;
            sclk_n  = cpol_q;
          end else begin
            ec_n              = ec + EcW'(1);
            sclk_n            = ~SCLK;
            {edge_n, shift_n} = edge_strobes(ec + EcW'(1), cpha_q);
          end
        end else begin
          hc_n = hc + DivW'(1);
        end
      end
      HOLD: begin
        busy_n = 1'b1;
        csn_n  = 1'b0;
        en_n   = 1'b1;
        sclk_n = cpol_q;
        if (hc == div_q) begin
          hc_n    = '0;
          ec_n    = '0;
          state_n = DONE;
          busy_n  = 1'b0;
          csn_n   = 1'b1;
          en_n    = 1'b0;
          done_n  = 1'b1;
        end else begin
          hc_n = hc + DivW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        sclk_n  = CPOL;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hc          <= '0;
      ec          <= '0;
      div_q       <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      SCLK        <= 1'b0;
      CS_n        <= 1'b1;
      EnSIPO      <= 1'b0;
      EnPISO      <= 1'b0;
      SCLKEdgeFlg <= 1'b0;
      LoadPISO    <= 1'b0;
      ShiftFlg    <= 1'b0;
    end else begin
      state       <= state_n;
      hc          <= hc_n;
      ec          <= ec_n;
      div_q       <= div_n;
      cpol_q      <= cpol_n;
      cpha_q      <= cpha_n;
      Busy        <= busy_n;
      Done        <= done_n;
      SCLK        <= sclk_n;
      CS_n        <= csn_n;
      EnSIPO      <= en_n;
      EnPISO      <= en_n;
      SCLKEdgeFlg <= edge_n;
      LoadPISO    <= load_n;
      ShiftFlg    <= shift_n;
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb/tb_spi_xfer_ctrl.sv - self-checking bench for spi_xfer_ctrl with a loopback PISO/SIPO model
module tb_spi_xfer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Start = 1'b0;
  logic [7:0] ClkDiv = 8'd0;
  logic       CPOL = 1'b0;
  logic       CPHA = 1'b0;
  logic       Busy, Done, SCLK, CS_n, EnSIPO, SCLKEdgeFlg, EnPISO, LoadPISO, ShiftFlg;

  spi_xfer_ctrl #(.WordLen(8), .DivW(8)) dut (
    .clk(clk), .rst(rst), .Start(Start), .ClkDiv(ClkDiv), .CPOL(CPOL), .CPHA(CPHA),
    .Busy(Busy), .Done(Done), .SCLK(SCLK), .CS_n(CS_n), .EnSIPO(EnSIPO),
    .SCLKEdgeFlg(SCLKEdgeFlg), .EnPISO(EnPISO), .LoadPISO(LoadPISO), .ShiftFlg(ShiftFlg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] div;
    logic       cpol;
    logic       cpha;
    logic [7:0] tx;
    int         exp_busy;
  } vec_t;

  // Per-transfer observations
  int n_busy, n_csl, n_edge, n_shift, n_load, load_bad, bad_align, n_rise, lat, t1, t2, timed_out;
  logic [7:0] piso, rx;
  logic done_sclk, done_csn;

  task automatic run_xfer(input logic [7:0] div, input logic cpol, input logic cpha, input logic [7:0] tx);
    int cyc;
    logic prev;
    ClkDiv = div; CPOL = cpol; CPHA = cpha;
    repeat (2) @(negedge clk);
    n_busy = 0; n_csl = 0; n_edge = 0; n_shift = 0; n_load = 0; load_bad = 0;
    bad_align = 0; n_rise = 0; lat = 0; t1 = -1; t2 = -1; timed_out = 1;
    piso = 8'h00; rx = 8'h00; done_sclk = 1'b0; done_csn = 1'b0;
    prev = SCLK;
    Start = 1'b1;
    cyc = 0;
    while (cyc < 6000) begin
      @(negedge clk);
      cyc++;
      Start = 1'b0;
      if (Busy) n_busy++;
      if (!CS_n) n_csl++;
      if (LoadPISO) begin
        n_load++;
        if (cyc != 1) load_bad++;
        piso = tx;
      end
      if (SCLK != prev) begin
        if (SCLK) n_rise++;
        if (t1 < 0) t1 = cyc;
        else if (t2 < 0) t2 = cyc;
      end
      // Sample edge shows level ~(CPOL^CPHA); shift edge shows CPOL^CPHA
      if (SCLKEdgeFlg) begin
        n_edge++;
        if (SCLK == prev || SCLK != ~(cpol ^ cpha)) bad_align++;
        rx = {rx[6:0], piso[7]};
      end
      if (ShiftFlg) begin
        n_shift++;
        if (SCLK == prev || SCLK != (cpol ^ cpha)) bad_align++;
        piso = {piso[6:0], 1'b0};
      end
      prev = SCLK;
      if (Done) begin
        lat = cyc; done_sclk = SCLK; done_csn = CS_n; timed_out = 0;
        break;
      end
    end
  endtask

  task automatic check_xfer(input string name, input logic [7:0] div, input logic cpol,
                            input logic cpha, input logic [7:0] tx, input int exp_busy);
    run_xfer(div, cpol, cpha, tx);
    chk({name, " timeout"}, timed_out, 0);
    chk({name, " busy"}, n_busy, exp_busy);
    chk({name, " cs_low"}, n_csl, exp_busy);
    chk({name, " latency"}, lat, exp_busy + 1);
    chk({name, " sample_cnt"}, n_edge, 8);
    chk({name, " shift_cnt"}, n_shift, 7);
    chk({name, " load_cnt"}, n_load, 1);
    chk({name, " load_pos"}, load_bad, 0);
    chk({name, " strobe_align"}, bad_align, 0);
    chk({name, " rises"}, n_rise, 8);
    chk({name, " half_period"}, t2 - t1, int'(div) + 1);
    chk({name, " rx"}, int'(rx), int'(tx));
    chk({name, " done_sclk"}, int'(done_sclk), int'(cpol));
    chk({name, " done_csn"}, int'(done_csn), 1);
  endtask

  initial begin
    vec_t vecs[6];
    int   wins[2];
    int   nwin, win, ndone, gap, toggles, cyc;
    logic prev;
    logic [7:0] rdiv, rtx;
    logic rcpol, rcpha;

    vecs[0] = '{div: 8'd1, cpol: 1'b0, cpha: 1'b0, tx: 8'hA5, exp_busy: 36};
    vecs[1] = '{div: 8'd0, cpol: 1'b1, cpha: 1'b1, tx: 8'hA5, exp_busy: 18};
    vecs[2] = '{div: 8'd0, cpol: 1'b0, cpha: 1'b1, tx: 8'hA5, exp_busy: 18};
    vecs[3] = '{div: 8'd2, cpol: 1'b1, cpha: 1'b0, tx: 8'hA5, exp_busy: 54};
    vecs[4] = '{div: 8'd3, cpol: 1'b0, cpha: 1'b0, tx: 8'h3C, exp_busy: 72};
    vecs[5] = '{div: 8'd1, cpol: 1'b1, cpha: 1'b1, tx: 8'h81, exp_busy: 36};

    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({Busy, Done, SCLK, CS_n, EnSIPO, EnPISO, SCLKEdgeFlg, LoadPISO, ShiftFlg}),
        int'(9'b0001_00000));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++)
      check_xfer($sformatf("vec%0d", i), vecs[i].div, vecs[i].cpol, vecs[i].cpha, vecs[i].tx, vecs[i].exp_busy);

    // Random transfers against the arithmetic model: busy = (div+1)*(2*8+2), rx = tx
    for (int i = 0; i < 8; i++) begin
      rdiv  = 8'($urandom_range(0, 6));
      rcpol = 1'($urandom_range(0, 1));
      rcpha = 1'($urandom_range(0, 1));
      rtx   = 8'($urandom_range(0, 255));
      check_xfer($sformatf("rnd%0d", i), rdiv, rcpol, rcpha, rtx, (int'(rdiv) + 1) * 18);
    end

    // Start held high: back-to-back transfers, ClkDiv change applies to the next one
    ClkDiv = 8'd2; CPOL = 1'b0; CPHA = 1'b0;
    repeat (2) @(negedge clk);
    Start = 1'b1;
    nwin = 0; win = 0; ndone = 0; gap = 0; cyc = 0;
    wins[0] = 0; wins[1] = 0;
    while (cyc < 500 && ndone < 2) begin
      @(negedge clk);
      cyc++;
      if (cyc == 20) ClkDiv = 8'd5;
      if (Busy) win++;
      else if (win > 0) begin
        if (nwin < 2) wins[nwin] = win;
        nwin++;
        win = 0;
      end
      if (Done) ndone++;
      if (CS_n && ndone == 1) gap++;
    end
    Start = 1'b0;
    chk("b2b_dones", ndone, 2);
    chk("b2b_win0", wins[0], 54);
    chk("b2b_win1", wins[1], 108);
    chk("b2b_gap_ge1", int'(gap >= 1), 1);
    repeat (4) @(negedge clk);
    chk("b2b_stops", int'(Busy), 0);

    // Reset on the 5th SCLK edge
    ClkDiv = 8'd1; CPOL = 1'b0; CPHA = 1'b0;
    repeat (2) @(negedge clk);
    prev = SCLK; toggles = 0; cyc = 0;
    Start = 1'b1;
    while (cyc < 200 && toggles < 5) begin
      @(negedge clk);
      cyc++;
      Start = 1'b0;
      if (SCLK != prev) toggles++;
      prev = SCLK;
    end
    chk("rst_reached_edge5", toggles, 5);
    rst = 1'b1;
    #1;
    chk("rst_midxfer_outputs", int'({Busy, Done, SCLK, CS_n, EnSIPO, EnPISO, SCLKEdgeFlg, LoadPISO, ShiftFlg}),
        int'(9'b0001_00000));
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (Done) ndone++;
    end
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (Done || Busy) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    check_xfer("after_rst", 8'd1, 1'b0, 1'b0, 8'hA5, 36);

    // SCLK follows CPOL in IDLE with one cycle of lag, then max divider
    ClkDiv = 8'hFF; CPOL = 1'b0;
    repeat (2) @(negedge clk);
    CPOL = 1'b1;
    #1;
    chk("idle_cpol_lag", int'(SCLK), 0);
    @(negedge clk);
    chk("idle_cpol_follow", int'(SCLK), 1);
    CPOL = 1'b0;
    @(negedge clk);
    chk("idle_cpol_back", int'(SCLK), 0);
    check_xfer("div_ff", 8'hFF, 1'b1, 1'b0, 8'h5A, 256 * 18);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
